// File: rtl/shift_unit_pipe.sv
// rtl/shift_unit_pipe.sv - pipelined SLL/SRL/SRA/ROL/ROR shifter with carry/zero flags
// One barrel stage per register; the whole pipe stalls together when the output is blocked.
module shift_unit_pipe #(
  parameter int WIDTH = 16,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] shamt,
  input  logic [TAG_W-1:0] tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             zero,
  output logic             illegal,
  output logic [TAG_W-1:0] out_tag
);

  localparam int STAGES = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] W_V = WIDTH'(WIDTH);

  localparam logic [2:0] OP_SLL = 3'b000;
  localparam logic [2:0] OP_SRL = 3'b001;
  localparam logic [2:0] OP_SRA = 3'b010;
  localparam logic [2:0] OP_ROL = 3'b011;
  localparam logic [2:0] OP_ROR = 3'b100;

  function automatic logic [WIDTH-1:0] barrel_step(input logic [WIDTH-1:0] d,
                                                   input logic [2:0] op_i,
                                                   input logic fill_i,
                                                   input logic en,
                                                   input int s);
    int amt;
    logic [WIDTH-1:0] fmask;
    amt = 1 << s;
    fmask = fill_i ? ~({WIDTH{1'b1}} >> amt) : '0;
    barrel_step = d;
    if (en) begin
      case (op_i)
        OP_SLL:         barrel_step = d << amt;
        OP_SRL, OP_SRA: barrel_step = (d >> amt) | fmask;
        OP_ROL:         barrel_step = (d << amt) | (d >> (WIDTH - amt));
        OP_ROR:         barrel_step = (d >> amt) | (d << (WIDTH - amt));
        default:        barrel_step = d;
      endcase
    end
  endfunction

  logic                w_adv;
  logic                w_rot;
  logic                w_shift;
  logic [STAGES-1:0]   w_k;
  logic [STAGES-1:0]   w_idx_l;
  logic [STAGES-1:0]   w_idx_r;
  logic                w_over;
  logic                w_fill;
  logic                w_in_range;
  logic                w_carry;
  logic [WIDTH-1:0]    w_final;

  logic                r_vld   [STAGES];
  logic [WIDTH-1:0]    r_data  [STAGES];
  logic                r_carry [STAGES];
  logic                r_ill   [STAGES];
  logic [TAG_W-1:0]    r_tag   [STAGES];
  logic [2:0]          r_op    [STAGES-1];
  logic [STAGES-1:0]   r_k     [STAGES-1];
  logic                r_fill  [STAGES-1];
  logic                r_over  [STAGES-1];
  logic                r_zero;

  assign w_adv    = !r_vld[STAGES-1] || out_ready;
  assign in_ready = w_adv;

  // Power-of-two WIDTH: shamt mod WIDTH is just the low bits, shared by shifts and rotates.
  // The bit that leaves last sits at index (WIDTH - n) mod WIDTH for left moves, n-1 for right.
  always_comb begin
    w_rot      = (op == OP_ROL) || (op == OP_ROR);
    w_shift    = (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
    w_k        = shamt[STAGES-1:0];
    w_idx_l    = '0 - w_k;
    w_idx_r    = w_k - STAGES'(1);
    w_over     = w_shift && (shamt >= W_V);
    w_fill     = (op == OP_SRA) && a[WIDTH-1];
    w_in_range = w_rot ? (w_k != '0) : ((shamt != '0) && (shamt <= W_V));
    w_carry    = 1'b0;
    case (op)
      OP_SLL, OP_ROL: w_carry = w_in_range && a[w_idx_l];
      OP_SRL, OP_ROR: w_carry = w_in_range && a[w_idx_r];
      OP_SRA:         w_carry = w_in_range ? a[w_idx_r] : ((shamt > W_V) && a[WIDTH-1]);
      default:        w_carry = 1'b0;
    endcase
  end

  always_comb begin
    w_final = barrel_step(r_data[STAGES-2], r_op[STAGES-2], r_fill[STAGES-2],
                          r_k[STAGES-2][STAGES-1], STAGES-1);
    if (r_over[STAGES-2]) begin
      w_final = {WIDTH{r_fill[STAGES-2]}};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int s = 0; s < STAGES; s++) begin
        r_vld[s]   <= 1'b0;
        r_data[s]  <= '0;
        r_carry[s] <= 1'b0;
        r_ill[s]   <= 1'b0;
        r_tag[s]   <= '0;
      end
      for (int s = 0; s < STAGES-1; s++) begin
        r_op[s]   <= '0;
        r_k[s]    <= '0;
        r_fill[s] <= 1'b0;
        r_over[s] <= 1'b0;
      end
      r_zero <= 1'b0;
    end else if (w_adv) begin
      r_vld[0]   <= in_valid;
      r_data[0]  <= barrel_step(a, op, w_fill, w_k[0], 0);
      r_carry[0] <= w_carry;
      r_ill[0]   <= !(w_rot || w_shift);
      r_tag[0]   <= tag;
      r_op[0]    <= op;
      r_k[0]     <= w_k;
      r_fill[0]  <= w_fill;
      r_over[0]  <= w_over;
      for (int s = 1; s < STAGES; s++) begin
        r_vld[s]   <= r_vld[s-1];
        r_carry[s] <= r_carry[s-1];
        r_ill[s]   <= r_ill[s-1];
        r_tag[s]   <= r_tag[s-1];
      end
      for (int s = 1; s < STAGES-1; s++) begin
        r_data[s] <= barrel_step(r_data[s-1], r_op[s-1], r_fill[s-1], r_k[s-1][s], s);
        r_op[s]   <= r_op[s-1];
        r_k[s]    <= r_k[s-1];
        r_fill[s] <= r_fill[s-1];
        r_over[s] <= r_over[s-1];
      end
      r_data[STAGES-1] <= w_final;
      r_zero           <= (w_final == '0);
    end
  end

  assign out_valid = r_vld[STAGES-1];
  assign result    = r_data[STAGES-1];
  assign carry     = r_carry[STAGES-1];
  assign zero      = r_zero;
  assign illegal   = r_ill[STAGES-1];
  assign out_tag   = r_tag[STAGES-1];

endmodule

// File: tb/tb_shift_unit_pipe.sv
// tb/tb_shift_unit_pipe.sv - scoreboard bench for shift_unit_pipe against a bit-serial model
module tb_shift_unit_pipe;
  localparam int W  = 16;
  localparam int TW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [2:0]    op;
  logic [W-1:0]  a;
  logic [W-1:0]  shamt;
  logic [TW-1:0] tag;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  result;
  logic          carry;
  logic          zero;
  logic          illegal;
  logic [TW-1:0] out_tag;

  shift_unit_pipe #(.WIDTH(W), .TAG_W(TW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .shamt(shamt), .tag(tag),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .carry(carry), .zero(zero), .illegal(illegal), .out_tag(out_tag)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0]  res;
    logic          c;
    logic          z;
    logic          ill;
    logic [TW-1:0] tg;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   n_out    = 0;
  logic in_fire;
  logic [TW-1:0] gtag = '0;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  // Moves the operand one bit at a time, so the last bit moved out is the carry.
  function automatic exp_t model(input logic [2:0] o, input logic [W-1:0] av,
                                 input logic [W-1:0] sh, input logic [TW-1:0] t);
    exp_t e;
    logic [W-1:0] x;
    logic c;
    int n;
    x = av;
    c = 1'b0;
    n = (sh > 40) ? 40 : int'(sh);
    case (o)
      3'd0: for (int i = 0; i < n; i++) begin c = x[W-1]; x = x << 1; end
      3'd1: for (int i = 0; i < n; i++) begin c = x[0]; x = x >> 1; end
      3'd2: for (int i = 0; i < n; i++) begin c = x[0]; x = {x[W-1], x[W-1:1]}; end
      3'd3: begin
        n = int'(sh % W);
        for (int i = 0; i < n; i++) x = {x[W-2:0], x[W-1]};
        c = (n != 0) ? x[0] : 1'b0;
      end
      3'd4: begin
        n = int'(sh % W);
        for (int i = 0; i < n; i++) x = {x[0], x[W-1:1]};
        c = (n != 0) ? x[W-1] : 1'b0;
      end
      default: x = av;
    endcase
    e.res = x;
    e.c   = c;
    e.z   = (x == '0);
    e.ill = (o > 3'd4);
    e.tg  = t;
    return e;
  endfunction

  task automatic cycle();
    exp_t e;
    @(negedge clk);
    in_fire = in_valid && in_ready;
    if (out_valid && out_ready) begin
      n_out++;
      if (q.size() == 0) begin
        check("spurious_out", 32'd1, 32'd0);
      end else begin
        e = q.pop_front();
        check("result", result, e.res);
        check("carry", carry, e.c);
        check("zero", zero, e.z);
        check("illegal", illegal, e.ill);
        check("tag", out_tag, e.tg);
      end
    end
    if (in_fire) q.push_back(model(op, a, shamt, tag));
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 20 && q.size() > 0; i++) cycle();
    check("drain_empty", q.size(), 0);
  endtask

  task automatic directed(input string nm, input logic [2:0] o, input logic [W-1:0] av,
                          input logic [W-1:0] sh, input logic [W-1:0] er,
                          input logic ec, input logic eill);
    int lat;
    op = o; a = av; shamt = sh; tag = gtag; gtag++;
    in_valid = 1'b1;
    out_ready = 1'b1;
    cycle();
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 12) begin
      cycle();
      lat++;
    end
    check({nm, "_lat"}, lat, 4);
    check({nm, "_res"}, result, er);
    check({nm, "_carry"}, carry, ec);
    check({nm, "_zero"}, zero, (er == '0));
    check({nm, "_ill"}, illegal, eill);
    cycle();
  endtask

  initial begin
    int sent;
    logic stall_done;
    logic [W-1:0] hold_r;
    logic [TW-1:0] hold_t;
    int n_out0;

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    op = '0; a = '0; shamt = '0; tag = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_result", result, 0);
    check("rst_carry", carry, 0);
    check("rst_zero", zero, 0);
    check("rst_illegal", illegal, 0);
    check("rst_out_tag", out_tag, 0);
    check("rst_in_ready", in_ready, 1);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    directed("sra1",   3'b010, 16'h8001, 16'd1,  16'hC000, 1'b1, 1'b0);
    directed("sra20",  3'b010, 16'h8000, 16'd20, 16'hFFFF, 1'b1, 1'b0);
    directed("srl20",  3'b001, 16'h8000, 16'd20, 16'h0000, 1'b0, 1'b0);
    directed("sll16",  3'b000, 16'h0001, 16'd16, 16'h0000, 1'b1, 1'b0);
    directed("srl256", 3'b001, 16'hFFFF, 16'h0100, 16'h0000, 1'b0, 1'b0);
    directed("rol17",  3'b011, 16'h8001, 16'd17, 16'h0003, 1'b1, 1'b0);
    directed("ror4",   3'b100, 16'h0001, 16'd4,  16'h1000, 1'b0, 1'b0);
    directed("pass",   3'b110, 16'h1234, 16'd3,  16'h1234, 1'b0, 1'b1);
    for (int o = 0; o < 5; o++) begin
      directed($sformatf("sh0_op%0d", o), 3'(o), 16'hB7E5, 16'd0, 16'hB7E5, 1'b0, 1'b0);
    end

    // Back-pressure: 8 tagged ops with a 5-cycle output stall once the pipe is full.
    sent = 0; stall_done = 1'b0; n_out0 = n_out; out_ready = 1'b1;
    for (int c = 0; c < 80 && (sent < 8 || q.size() > 0); c++) begin
      if (sent < 8) begin
        in_valid = 1'b1;
        op = 3'(sent % 5);
        a = 16'hA5C3 ^ 16'(sent * 16'h1111);
        shamt = 16'(sent + 1);
        tag = 4'(sent);
      end else begin
        in_valid = 1'b0;
      end
      if (sent == 5 && !stall_done) begin
        stall_done = 1'b1;
        out_ready = 1'b0;
        check("bp_out_valid", out_valid, 1);
        hold_r = result;
        hold_t = out_tag;
        repeat (5) begin
          cycle();
          check("bp_in_ready", in_ready, 0);
          check("bp_valid_hold", out_valid, 1);
          check("bp_result_hold", result, hold_r);
          check("bp_tag_hold", out_tag, hold_t);
        end
        out_ready = 1'b1;
      end
      cycle();
      if (in_fire) sent++;
    end
    check("bp_sent", sent, 8);
    check("bp_out_count", n_out - n_out0, 8);
    drain();

    // Reset with three ops in flight: none of them may come out.
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; op = 3'(i); a = 16'h0F0F; shamt = 16'(i + 2); tag = 4'(9 + i);
      cycle();
    end
    in_valid = 1'b0;
    rst_n = 1'b0;
    cycle();
    q.delete();
    rst_n = 1'b1;
    check("midrst_out_valid", out_valid, 0);
    n_out0 = n_out;
    repeat (8) cycle();
    check("midrst_no_out", n_out - n_out0, 0);

    // Random traffic with random back-pressure.
    for (int i = 0; i < 400; i++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      op = 3'($urandom_range(0, 7));
      a = 16'($urandom);
      case ($urandom_range(0, 3))
        0: shamt = 16'($urandom_range(0, W + 4));
        1: shamt = 16'($urandom);
        2: shamt = 16'(W);
        default: shamt = 16'($urandom_range(0, 3));
      endcase
      tag = 4'($urandom);
      cycle();
    end
    drain();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
